// File: rtl/runner_pkg.sv
// runner_pkg: shared types and default physics constants for the runner motion block.
// Optional feature macro: RUNNER_DOUBLE_JUMP_EN (consumed in runner_motion.sv).
package runner_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_DEAD   = 2'd3
  } runner_state_t;

  localparam logic [1:0] GS_START = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_OVER  = 2'b10;

  localparam int RUNNER_X_DEF = 40;
  localparam int GROUND_Y_DEF = 300;
  localparam int JUMP_V_DEF   = 20;
  localparam int GRAVITY_DEF  = 1;

  // Signed 8-bit velocity add that sticks at the rails instead of wrapping.
  function automatic logic signed [7:0] vel_add(input logic signed [7:0] v,
                                                input logic signed [7:0] g);
    logic signed [8:0] s;
    s = {v[7], v} + {g[7], g};
    if (s > 9'sd127)
      return 8'sd127;
    else if (s < -9'sd128)
      return -8'sd128;
    else
      return s[7:0];
  endfunction

endpackage

// File: rtl/runner_motion_if.sv
// runner_motion_if: per-frame control inputs and position/status outputs of the runner.
interface runner_motion_if;
  logic              frame_tick;
  logic [1:0]        Game_State;
  logic              jump_key;
  logic              collision;
  logic [9:0]        PosX;
  logic [9:0]        PosY;
  logic signed [7:0] VelY;
  logic              airborne;
  logic              Dead;

  modport master (
    output frame_tick, Game_State, jump_key, collision,
    input  PosX, PosY, VelY, airborne, Dead
  );

  modport slave (
    input  frame_tick, Game_State, jump_key, collision,
    output PosX, PosY, VelY, airborne, Dead
  );
endinterface

// File: rtl/runner_edge_latch.sv
// runner_edge_latch: rising-edge detector on jump_key with a sticky request bit
// that survives until the next frame_tick, so sub-frame presses are never lost.
module runner_edge_latch (
  input  logic Clk50,
  input  logic Reset_n,
  input  logic jump_key,
  input  logic frame_tick,
  output logic jump_req
);

  logic key_q;
  logic key_rise;

  assign key_rise = jump_key & ~key_q;

  // Track the previous key level and hold a request until the frame consumes it.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk50) begin
    // NOTE: reset is synchronous -- it is only seen on a clock edge, never as an async clear.
    if (!Reset_n) begin
      key_q    <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      key_q    <= jump_key;
      // A press landing on the tick cycle itself is kept for the following frame.
      jump_req <= key_rise | (jump_req & ~frame_tick);
    end
  end

endmodule

// File: rtl/runner_motion.sv
// runner_motion: per-frame runner physics (ground run, jump arc, freeze on death).
// Optional feature: define RUNNER_DOUBLE_JUMP_EN to allow one extra jump per airtime.
module runner_motion
  import runner_pkg::*;
#(
  parameter int RUNNER_X = RUNNER_X_DEF,
  parameter int GROUND_Y = GROUND_Y_DEF,
  parameter int JUMP_V   = JUMP_V_DEF,
  parameter int GRAVITY  = GRAVITY_DEF
) (
  input  logic            Clk50,
  input  logic            Reset_n,
  runner_motion_if.slave  bus
);

`ifdef RUNNER_DOUBLE_JUMP_EN
  localparam bit AIR_JUMP = 1'b1;
`else
  localparam bit AIR_JUMP = 1'b0;
`endif

  localparam logic [9:0]        GROUND_Y_U = 10'(GROUND_Y);
  localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
  localparam logic [9:0]        LAUNCH_Y   = 10'(GROUND_Y - JUMP_V);
  localparam logic signed [7:0] LAUNCH_V   = 8'(GRAVITY - JUMP_V);
  localparam logic signed [7:0] AIR_V      = 8'(-JUMP_V);
  localparam logic signed [7:0] GRAV_V     = 8'(GRAVITY);

  runner_state_t     state;
  logic [9:0]        pos_y;
  logic signed [7:0] vel_y;
  logic              air_q;
  logic              dead_q;
  logic              air_used;
  logic              jump_req;
  logic              gs_start;
  logic signed [10:0] pos_sum;
  logic signed [7:0]  vel_next;

  runner_edge_latch u_edge (
    .Clk50      (Clk50),
    .Reset_n    (Reset_n),
    .jump_key   (bus.jump_key),
    .frame_tick (bus.frame_tick),
    .jump_req   (jump_req)
  );

  // Game_State 11 is an alias of start.
  assign gs_start = (bus.Game_State == GS_START) || (bus.Game_State == 2'b11);

  // Candidate airborne position and velocity for this frame.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pos_sum  = '0;
    vel_next = vel_y;
    pos_sum  = $signed({1'b0, pos_y}) + {{3{vel_y[7]}}, vel_y};
    vel_next = vel_add(vel_y, GRAV_V);
  end

  // Runner FSM: restart/death priority, then per-frame physics.
  always_ff @(posedge Clk50) begin
    if (!Reset_n || gs_start) begin
      state    <= ST_GROUND;
      pos_y    <= GROUND_Y_U;
      vel_y    <= '0;
      air_q    <= 1'b0;
      dead_q   <= 1'b0;
      air_used <= 1'b0;
    end else if (state == ST_DEAD) begin
      // Frozen until restart.
    end else if (bus.Game_State == GS_OVER || bus.collision) begin
      // Here Game_State is PLAY or OVER; collision beats a coincident tick.
      state  <= ST_DEAD;
      dead_q <= 1'b1;
    end else if (bus.frame_tick) begin
      case (state)
        ST_GROUND: begin
          if (jump_req) begin
            pos_y <= LAUNCH_Y;
            vel_y <= LAUNCH_V;
            air_q <= 1'b1;
            state <= ST_RISE;
          end
        end
        default: begin
          if (AIR_JUMP && jump_req && !air_used) begin
            vel_y    <= AIR_V;
            air_used <= 1'b1;
            state    <= ST_RISE;
          end else if (pos_sum >= GROUND_Y_S) begin
            pos_y    <= GROUND_Y_U;
            vel_y    <= '0;
            air_q    <= 1'b0;
            air_used <= 1'b0;
            state    <= ST_GROUND;
          end else begin
            pos_y <= pos_sum[10] ? 10'd0 : pos_sum[9:0];
            vel_y <= vel_next;
            state <= vel_next[7] ? ST_RISE : ST_FALL;
          end
        end
      endcase
    end
  end

  assign bus.PosX     = 10'(RUNNER_X);
  assign bus.PosY     = pos_y;
  assign bus.VelY     = vel_y;
  assign bus.airborne = air_q;
  assign bus.Dead     = dead_q;

endmodule

// File: tb/tb_runner_motion.sv
// tb_runner_motion: directed self-checking bench for runner_motion.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_runner_motion;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  runner_motion_if bus ();

  runner_motion dut (
    .Clk50   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic press();
    @(negedge clk);
    bus.jump_key = 1'b1;
    @(negedge clk);
    bus.jump_key = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.Game_State = 2'b00;
    bus.jump_key   = 1'b0;
    bus.collision  = 1'b0;

    // Reset state
    cyc(2);
    check("rst_posx", bus.PosX, 40);
    check("rst_posy", bus.PosY, 300);
    check("rst_vely", bus.VelY, 0);
    check("rst_dead", bus.Dead, 0);
    check("rst_air",  bus.airborne, 0);

    // Full jump arc
    rst_n = 1'b1;
    bus.Game_State = 2'b01;
    cyc(2);
    press();
    cyc(3);
    tick(1);
    check("t1_posy", bus.PosY, 280);
    check("t1_vely", bus.VelY, -19);
    check("t1_air",  bus.airborne, 1);
    tick(19);
    check("apex_posy", bus.PosY, 90);
    check("apex_vely", bus.VelY, 0);
    tick(4);
    press();
    tick(1);
`ifdef RUNNER_DOUBLE_JUMP_EN
    check("dj_vely", bus.VelY, -20);
    check("dj_posy", bus.PosY, 96);
    press();
    tick(1);
    check("dj2_vely", bus.VelY, -19);
    check("dj2_posy", bus.PosY, 76);
    bus.Game_State = 2'b00;
    cyc(1);
    bus.Game_State = 2'b01;
    check("dj_ground", bus.PosY, 300);
`else
    check("air_press_posy", bus.PosY, 100);
    check("air_press_vely", bus.VelY, 5);
    tick(16);
    check("land_posy", bus.PosY, 300);
    check("land_air",  bus.airborne, 0);
    check("land_vely", bus.VelY, 0);
`endif

    // Collision on the same cycle as tick 10
    cyc(2);
    press();
    tick(9);
    check("t9_posy", bus.PosY, 156);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.collision  = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.collision  = 1'b0;
    check("col_dead", bus.Dead, 1);
    check("col_posy", bus.PosY, 156);
    tick(3);
    check("frozen_posy", bus.PosY, 156);
    check("frozen_vely", bus.VelY, -11);
    check("frozen_dead", bus.Dead, 1);

    // Restart, then jump ignored while in start
    bus.Game_State = 2'b00;
    cyc(1);
    check("restart_posy", bus.PosY, 300);
    check("restart_dead", bus.Dead, 0);
    check("restart_air",  bus.airborne, 0);
    press();
    tick(1);
    check("start_jump_posy", bus.PosY, 300);
    check("start_jump_air",  bus.airborne, 0);
    bus.Game_State = 2'b01;
    tick(1);
    check("stale_req_air", bus.airborne, 0);

    // Reset mid-jump
    press();
    tick(9);
    check("mid_posy", bus.PosY, 156);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("midrst_posy", bus.PosY, 300);
    check("midrst_vely", bus.VelY, 0);
    check("midrst_air",  bus.airborne, 0);

    // Game over forces death, start clears it
    cyc(1);
    bus.Game_State = 2'b10;
    cyc(1);
    check("over_dead", bus.Dead, 1);
    bus.Game_State = 2'b11;
    cyc(1);
    check("gs11_restart", bus.Dead, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
